// File: rtl/fmulsu.sv
// Signed-by-unsigned fractional multiplier (FMULSU): iterative shift-add,
// one multiplier bit per clock, result left-shifted by one into r1:r0.
module fmulsu #(
  parameter int unsigned DATA_W = 8
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic              i_start,
  input  logic [DATA_W-1:0] i_rd,
  input  logic [DATA_W-1:0] i_rr,
  output logic [DATA_W-1:0] o_r1,
  output logic [DATA_W-1:0] o_r0,
  output logic              o_c,
  output logic              o_z,
  output logic              o_busy,
  output logic              o_done
);

  localparam int unsigned PW = 2 * DATA_W;
  localparam int unsigned CW = $clog2(DATA_W);

  typedef enum logic {S_IDLE, S_RUN} state_t;

  state_t          state;
  logic [PW-1:0]   mcand;
  logic [DATA_W-1:0] mplier;
  logic [PW-1:0]   acc;
  logic [CW-1:0]   cnt;

  logic [PW-1:0]   acc_next_c;
  logic [PW-1:0]   prod_sh_c;

  // One partial product per cycle; the shifted product is only used on the last step.
  always_comb begin
    acc_next_c = acc;
    if (mplier[cnt]) acc_next_c = acc + (mcand << cnt);
    prod_sh_c  = {acc_next_c[PW-2:0], 1'b0};
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state  <= S_IDLE;
      mcand  <= '0;
      mplier <= '0;
      acc    <= '0;
      cnt    <= '0;
      o_r1   <= '0;
      o_r0   <= '0;
      o_c    <= 1'b0;
      o_z    <= 1'b0;
      o_busy <= 1'b0;
      o_done <= 1'b0;
    end else begin
      o_done <= 1'b0;
      case (state)
        S_IDLE: begin
          if (i_start) begin
            mcand  <= {{DATA_W{i_rd[DATA_W-1]}}, i_rd};
            mplier <= i_rr;
            acc    <= '0;
            cnt    <= '0;
            o_busy <= 1'b1;
            state  <= S_RUN;
          end
        end
        S_RUN: begin
          acc <= acc_next_c;
          cnt <= cnt + CW'(1);
          // Last multiplier bit: publish result; a start on this edge is not seen.
          if (cnt == CW'(DATA_W - 1)) begin
            o_r1   <= prod_sh_c[PW-1:DATA_W];
            o_r0   <= prod_sh_c[DATA_W-1:0];
            o_c    <= acc_next_c[PW-1];
            o_z    <= (prod_sh_c == '0);
            o_busy <= 1'b0;
            o_done <= 1'b1;
            state  <= S_IDLE;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_fmulsu.sv
// Directed-vector bench for fmulsu: latency, flags, busy/start interaction, reset abort.
module tb_fmulsu;

  logic       clk;
  logic       rst_n;
  logic       start;
  logic [7:0] rd;
  logic [7:0] rr;
  logic [7:0] r1;
  logic [7:0] r0;
  logic       c;
  logic       z;
  logic       busy;
  logic       done;

  int total = 0;
  int bad   = 0;

  fmulsu #(.DATA_W(8)) dut (
    .i_clk   (clk),
    .i_rst_n (rst_n),
    .i_start (start),
    .i_rd    (rd),
    .i_rr    (rr),
    .o_r1    (r1),
    .o_r0    (r0),
    .o_c     (c),
    .o_z     (z),
    .o_busy  (busy),
    .o_done  (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic chk_res(input string tag, input logic [7:0] e1, input logic [7:0] e0,
                         input logic ec, input logic ez);
    chk({tag, "_r1"}, 16'(r1), 16'(e1));
    chk({tag, "_r0"}, 16'(r0), 16'(e0));
    chk({tag, "_c"},  16'(c),  16'(ec));
    chk({tag, "_z"},  16'(z),  16'(ez));
  endtask

  // Called at a falling edge; start is sampled at the next rising edge (edge N).
  task automatic run_op(input string tag, input logic [7:0] a, input logic [7:0] b,
                        input logic [7:0] e1, input logic [7:0] e0,
                        input logic ec, input logic ez);
    int lat;
    rd = a; rr = b; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    chk({tag, "_busy"}, 16'(busy), 16'd1);
    lat = 0;
    while (!done && lat < 30) begin
      @(negedge clk);
      lat++;
    end
    chk({tag, "_lat"}, 16'(lat), 16'd8);
    chk({tag, "_busy_end"}, 16'(busy), 16'd0);
    chk_res(tag, e1, e0, ec, ez);
    @(negedge clk);
    chk({tag, "_done_1cyc"}, 16'(done), 16'd0);
  endtask

  initial begin
    int lat;
    int ndone;
    rst_n = 1'b0; start = 1'b0; rd = '0; rr = '0;
    repeat (2) @(negedge clk);
    chk_res("rst", 8'h00, 8'h00, 1'b0, 1'b0);
    chk("rst_busy", 16'(busy), 16'd0);
    chk("rst_done", 16'(done), 16'd0);
    rst_n = 1'b1;

    run_op("m_b4x59", 8'hB4, 8'h59, 8'hCB, 8'h28, 1'b1, 1'b0);
    run_op("m_80x80", 8'h80, 8'h80, 8'h80, 8'h00, 1'b1, 1'b0);
    run_op("m_80x00", 8'h80, 8'h00, 8'h00, 8'h00, 1'b0, 1'b1);
    run_op("m_40x40", 8'h40, 8'h40, 8'h20, 8'h00, 1'b0, 1'b0);
    run_op("m_40xc0", 8'h40, 8'hC0, 8'h60, 8'h00, 1'b0, 1'b0);
    run_op("m_01x01", 8'h01, 8'h01, 8'h00, 8'h02, 1'b0, 1'b0);
    run_op("m_ffxff", 8'hFF, 8'hFF, 8'hFE, 8'h02, 1'b1, 1'b0);

    // Start pulse and operand changes while busy must not disturb the operation.
    rd = 8'h40; rr = 8'h40; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    ndone = 0;
    for (int i = 0; i < 14; i++) begin
      if (i == 3) begin rd = 8'hFF; rr = 8'hFF; start = 1'b1; end
      if (i == 4) start = 1'b0;
      @(negedge clk);
      if (done) ndone++;
    end
    chk("busy_ign_ndone", 16'(ndone), 16'd1);
    chk_res("busy_ign", 8'h20, 8'h00, 1'b0, 1'b0);

    // Reset at iteration 4 aborts immediately; no done afterwards.
    rd = 8'hB4; rr = 8'h59; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (3) @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk_res("rst_mid", 8'h00, 8'h00, 1'b0, 1'b0);
    chk("rst_mid_busy", 16'(busy), 16'd0);
    ndone = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (done) ndone++;
    end
    rst_n = 1'b1;
    chk("rst_mid_nodone", 16'(ndone), 16'd0);
    run_op("post_rst", 8'hB4, 8'h59, 8'hCB, 8'h28, 1'b1, 1'b0);

    // Held start: ignored on completion edge, relaunched on the next edge.
    rd = 8'h01; rr = 8'h01; start = 1'b1;
    @(negedge clk);
    lat = 0;
    while (!done && lat < 30) begin
      @(negedge clk);
      lat++;
    end
    chk("held1_lat", 16'(lat), 16'd8);
    chk_res("held1", 8'h00, 8'h02, 1'b0, 1'b0);
    chk("held_gap_busy", 16'(busy), 16'd0);
    rd = 8'h40; rr = 8'hC0;
    @(negedge clk);
    chk("held2_busy", 16'(busy), 16'd1);
    lat = 1;
    while (!done && lat < 30) begin
      @(negedge clk);
      lat++;
    end
    start = 1'b0;
    chk("held2_lat", 16'(lat), 16'd9);
    chk_res("held2", 8'h60, 8'h00, 1'b0, 1'b0);
    @(negedge clk);
    chk("held2_done_1cyc", 16'(done), 16'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
